// File: rtl/control_unit_if.sv
// control_unit_if
// Bundles the instruction handshake and the datapath control signals of the
// RV64 control unit so the FSM and its environment share one port.
//
// Signals:
//   cu_instr / cu_instr_valid / cu_instr_ready : instruction valid/ready handshake
//   cu_alu_zero                                : ALU result == 0, from the datapath
//   cu_rf_addr_a / cu_rf_addr_b / cu_rf_write_addr / cu_rf_write_en : register file
//   cu_immediate                               : sign-extended immediate
//   cu_mux_0_sel / cu_mux_1_sel / cu_mux_2_sel : datapath mux selects
//   cu_alu_operation                           : 0 add, 1 sub, 2 and, 3 or, 4 xor
//   cu_dm_write_en                             : data-memory write strobe
//   cu_branch_taken / cu_illegal               : one-cycle status pulses
//
// Modports:
//   slave  : the control unit itself
//   master : the instruction source / datapath driving it
interface control_unit_if #(
    parameter int WORDSIZE = 64
);
    logic [31:0]         cu_instr;
    logic                cu_instr_valid;
    logic                cu_instr_ready;
    logic                cu_alu_zero;
    logic [4:0]          cu_rf_addr_a;
    logic [4:0]          cu_rf_addr_b;
    logic [4:0]          cu_rf_write_addr;
    logic                cu_rf_write_en;
    logic [WORDSIZE-1:0] cu_immediate;
    logic                cu_mux_0_sel;
    logic                cu_mux_1_sel;
    logic                cu_mux_2_sel;
    logic [2:0]          cu_alu_operation;
    logic                cu_dm_write_en;
    logic                cu_branch_taken;
    logic                cu_illegal;

    modport slave (
        input  cu_instr, cu_instr_valid, cu_alu_zero,
        output cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
               cu_rf_write_en, cu_immediate, cu_mux_0_sel, cu_mux_1_sel,
               cu_mux_2_sel, cu_alu_operation, cu_dm_write_en,
               cu_branch_taken, cu_illegal
    );

    modport master (
        output cu_instr, cu_instr_valid, cu_alu_zero,
        input  cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
               cu_rf_write_en, cu_immediate, cu_mux_0_sel, cu_mux_1_sel,
               cu_mux_2_sel, cu_alu_operation, cu_dm_write_en,
               cu_branch_taken, cu_illegal
    );
endinterface

// File: rtl/control_unit.sv
// control_unit
// Multi-cycle RV64 control FSM. Accepts one instruction per valid/ready
// handshake, decodes it and walks the datapath through EXEC / MEM / WB,
// one state per clock. Supports ADD, SUB, AND, OR, XOR, ADDI, LD, SD, BEQ.
//
// Ports:
//   cu_clk   : clock, all state updates on the rising edge
//   cu_rst_n : asynchronous active-low reset
//   bus      : control_unit_if.slave (handshake, ALU zero flag, all control outputs)
//
// Parameter WORDSIZE must match the WORDSIZE of the connected interface.
module control_unit #(
    parameter int WORDSIZE = 64
) (
    input  logic          cu_clk,
    input  logic          cu_rst_n,
    control_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    // What the instruction needs after DECODE; decides the state sequence.
    typedef enum logic [1:0] {
        KIND_REG,
        KIND_LOAD,
        KIND_STORE,
        KIND_BRANCH
    } kind_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t              state;
    kind_t               kind_q;
    logic                ready_q;
    logic                illegal_q;
    logic                rf_write_en_q;
    logic                dm_write_en_q;
    logic                branch_arm_q;
    logic [4:0]          addr_a_q;
    logic [4:0]          addr_b_q;
    logic [4:0]          write_addr_q;
    logic [WORDSIZE-1:0] immediate_q;
    logic                mux_1_q;
    logic                mux_2_q;
    logic [2:0]          alu_op_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = bus.cu_instr[6:0];
    assign rd     = bus.cu_instr[11:7];
    assign funct3 = bus.cu_instr[14:12];
    assign rs1    = bus.cu_instr[19:15];
    assign rs2    = bus.cu_instr[24:20];
    assign funct7 = bus.cu_instr[31:25];

    logic                dec_legal;
    kind_t               dec_kind;
    logic [4:0]          dec_addr_b;
    logic [4:0]          dec_write_addr;
    logic [WORDSIZE-1:0] dec_imm;
    logic                dec_mux_1;
    logic                dec_mux_2;
    logic [2:0]          dec_alu_op;

    // Decode the word on the bus so the field registers are already valid
    // during the DECODE cycle. Stores and branches have no destination, so
    // their write address is forced to 0 instead of exposing immediate bits.
    always_comb begin
        dec_legal      = 1'b0;
        dec_kind       = KIND_REG;
        dec_addr_b     = 5'd0;
        dec_write_addr = rd;
        dec_imm        = '0;
        dec_mux_1      = 1'b0;
        dec_mux_2      = 1'b0;
        dec_alu_op     = ALU_ADD;
        case (opcode)
            OP_REG: begin
                dec_addr_b = rs2;
                dec_mux_1  = 1'b1;
                if (funct7 == 7'h00) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_alu_op = ALU_ADD;
                        3'b111:  dec_alu_op = ALU_AND;
                        3'b110:  dec_alu_op = ALU_OR;
                        3'b100:  dec_alu_op = ALU_XOR;
                        default: dec_legal  = 1'b0;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec_legal  = 1'b1;
                    dec_alu_op = ALU_SUB;
                end
            end
            OP_IMM: begin
                dec_legal = (funct3 == 3'b000);
                dec_imm   = {{(WORDSIZE-12){bus.cu_instr[31]}}, bus.cu_instr[31:20]};
            end
            OP_LOAD: begin
                dec_legal = (funct3 == 3'b011);
                dec_kind  = KIND_LOAD;
                dec_mux_2 = 1'b1;
                dec_imm   = {{(WORDSIZE-12){bus.cu_instr[31]}}, bus.cu_instr[31:20]};
            end
            OP_STORE: begin
                dec_legal      = (funct3 == 3'b011);
                dec_kind       = KIND_STORE;
                dec_addr_b     = rs2;
                dec_write_addr = 5'd0;
                dec_imm        = {{(WORDSIZE-12){bus.cu_instr[31]}},
                                  bus.cu_instr[31:25], bus.cu_instr[11:7]};
            end
            OP_BRANCH: begin
                dec_legal      = (funct3 == 3'b000);
                dec_kind       = KIND_BRANCH;
                dec_addr_b     = rs2;
                dec_write_addr = 5'd0;
                dec_mux_1      = 1'b1;
                dec_alu_op     = ALU_SUB;
                dec_imm        = {{(WORDSIZE-13){bus.cu_instr[31]}}, bus.cu_instr[31],
                                  bus.cu_instr[7], bus.cu_instr[30:25],
                                  bus.cu_instr[11:8], 1'b0};
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Main FSM. Every output is a flop loaded on the edge that enters the
    // state in which it must be visible, so strobes depend on state only.
    // Field registers load on accept (legal words only) and then hold.
    always_ff @(posedge cu_clk or negedge cu_rst_n) begin
        if (!cu_rst_n) begin
            state         <= IDLE;
            kind_q        <= KIND_REG;
            ready_q       <= 1'b1;
            illegal_q     <= 1'b0;
            rf_write_en_q <= 1'b0;
            dm_write_en_q <= 1'b0;
            branch_arm_q  <= 1'b0;
            addr_a_q      <= 5'd0;
            addr_b_q      <= 5'd0;
            write_addr_q  <= 5'd0;
            immediate_q   <= '0;
            mux_1_q       <= 1'b0;
            mux_2_q       <= 1'b0;
            alu_op_q      <= ALU_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cu_instr_valid) begin
                        state     <= DECODE;
                        ready_q   <= 1'b0;
                        kind_q    <= dec_kind;
                        illegal_q <= !dec_legal;
                        if (dec_legal) begin
                            addr_a_q     <= rs1;
                            addr_b_q     <= dec_addr_b;
                            write_addr_q <= dec_write_addr;
                            immediate_q  <= dec_imm;
                            mux_1_q      <= dec_mux_1;
                            mux_2_q      <= dec_mux_2;
                            alu_op_q     <= dec_alu_op;
                        end
                    end
                end
                DECODE: begin
                    illegal_q <= 1'b0;
                    if (illegal_q) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state        <= EXEC;
                        branch_arm_q <= (kind_q == KIND_BRANCH);
                    end
                end
                EXEC: begin
                    branch_arm_q <= 1'b0;
                    if (kind_q == KIND_REG) begin
                        state         <= WB;
                        rf_write_en_q <= (write_addr_q != 5'd0);
                    end else if (kind_q == KIND_BRANCH) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state         <= MEM;
                        dm_write_en_q <= (kind_q == KIND_STORE);
                    end
                end
                MEM: begin
                    dm_write_en_q <= 1'b0;
                    if (kind_q == KIND_LOAD) begin
                        state         <= WB;
                        rf_write_en_q <= (write_addr_q != 5'd0);
                    end else begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                WB: begin
                    rf_write_en_q <= 1'b0;
                    state         <= IDLE;
                    ready_q       <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    ready_q       <= 1'b1;
                    illegal_q     <= 1'b0;
                    rf_write_en_q <= 1'b0;
                    dm_write_en_q <= 1'b0;
                    branch_arm_q  <= 1'b0;
                end
            endcase
        end
    end

    // The branch outcome is only known from the ALU during EXEC itself,
    // so the registered EXEC-of-BEQ flag is gated with the live zero flag.
    assign bus.cu_branch_taken = branch_arm_q & bus.cu_alu_zero;

    // ALU input A is always rs1 for the supported instruction subset.
    assign bus.cu_mux_0_sel     = 1'b0;
    assign bus.cu_instr_ready   = ready_q;
    assign bus.cu_illegal       = illegal_q;
    assign bus.cu_rf_write_en   = rf_write_en_q;
    assign bus.cu_dm_write_en   = dm_write_en_q;
    assign bus.cu_rf_addr_a     = addr_a_q;
    assign bus.cu_rf_addr_b     = addr_b_q;
    assign bus.cu_rf_write_addr = write_addr_q;
    assign bus.cu_immediate     = immediate_q;
    assign bus.cu_mux_1_sel     = mux_1_q;
    assign bus.cu_mux_2_sel     = mux_2_q;
    assign bus.cu_alu_operation = alu_op_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
// Self-checking bench for control_unit: a table of directed instructions,
// hand-written reset sequences and randomized instructions checked against a
// behavioural model of the instruction set and its cycle timing.
module tb_control_unit;

    localparam int WORDSIZE = 64;

    localparam int K_REG     = 0;
    localparam int K_LOAD    = 1;
    localparam int K_STORE   = 2;
    localparam int K_BRANCH  = 3;
    localparam int K_ILLEGAL = 4;

    typedef struct packed {
        int          kind;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  wa;
        logic [63:0] imm;
        logic        mux1;
        logic        mux2;
        logic [2:0]  op;
    } model_t;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        model_t      exp;
    } vector_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    model_t held;

    always #5 clk = ~clk;

    control_unit_if #(.WORDSIZE(WORDSIZE)) cu_bus ();

    control_unit #(.WORDSIZE(WORDSIZE)) dut (
        .cu_clk   (clk),
        .cu_rst_n (rst_n),
        .bus      (cu_bus)
    );

    function automatic model_t make_exp(input int kind, input logic [4:0] a,
                                        input logic [4:0] b, input logic [4:0] wa,
                                        input logic [63:0] imm, input logic mux1,
                                        input logic mux2, input logic [2:0] op);
        model_t m;
        m.kind = kind; m.a = a; m.b = b; m.wa = wa; m.imm = imm;
        m.mux1 = mux1; m.mux2 = mux2; m.op = op;
        return m;
    endfunction

    // Instruction-set model: fields and immediates from the RISC-V formats.
    function automatic model_t model_decode(input logic [31:0] ins);
        model_t m;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        longint v;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        m = make_exp(K_ILLEGAL, ins[19:15], 5'd0, ins[11:7], 64'd0, 1'b0, 1'b0, 3'd0);
        if (opc == 7'h33) begin
            m.b = ins[24:20];
            m.mux1 = 1'b1;
            if (f7 == 7'h00 && f3 == 3'd0) begin m.kind = K_REG; m.op = 3'd0; end
            if (f7 == 7'h20 && f3 == 3'd0) begin m.kind = K_REG; m.op = 3'd1; end
            if (f7 == 7'h00 && f3 == 3'd7) begin m.kind = K_REG; m.op = 3'd2; end
            if (f7 == 7'h00 && f3 == 3'd6) begin m.kind = K_REG; m.op = 3'd3; end
            if (f7 == 7'h00 && f3 == 3'd4) begin m.kind = K_REG; m.op = 3'd4; end
        end else if ((opc == 7'h13 && f3 == 3'd0) || (opc == 7'h03 && f3 == 3'd3)) begin
            i12 = ins[31:20];
            v = i12;
            m.imm = v;
            m.kind = (opc == 7'h13) ? K_REG : K_LOAD;
            m.mux2 = (opc == 7'h03);
        end else if (opc == 7'h23 && f3 == 3'd3) begin
            i12 = {ins[31:25], ins[11:7]};
            v = i12;
            m.imm = v;
            m.kind = K_STORE;
            m.b = ins[24:20];
            m.wa = 5'd0;
        end else if (opc == 7'h63 && f3 == 3'd0) begin
            b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            v = b13;
            m.imm = v;
            m.kind = K_BRANCH;
            m.b = ins[24:20];
            m.wa = 5'd0;
            m.mux1 = 1'b1;
            m.op = 3'd1;
        end
        return m;
    endfunction

    function automatic int cycles_of(input int kind);
        case (kind)
            K_REG:    return 4;
            K_LOAD:   return 5;
            K_STORE:  return 4;
            K_BRANCH: return 3;
            default:  return 2;
        endcase
    endfunction

    function automatic logic [31:0] random_instr();
        logic [31:0] w;
        logic [11:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        imm = 12'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        rd  = 5'($urandom);
        f3  = 3'($urandom);
        f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 6))
            0:       w = {f7, rs2, rs1, f3, rd, 7'h33};
            1:       w = {imm, rs1, 3'b000, rd, 7'h13};
            2:       w = {imm, rs1, 3'b011, rd, 7'h03};
            3:       w = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'h23};
            4:       w = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'h63};
            5:       w = {imm, rs1, f3, rd, 7'h03};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input logic ready, input logic rf_we,
                               input logic dm_we, input logic br, input logic ill);
        check_output({tag, " ready"},      64'(cu_bus.cu_instr_ready), 64'(ready));
        check_output({tag, " rf_write_en"}, 64'(cu_bus.cu_rf_write_en), 64'(rf_we));
        check_output({tag, " dm_write_en"}, 64'(cu_bus.cu_dm_write_en), 64'(dm_we));
        check_output({tag, " branch"},     64'(cu_bus.cu_branch_taken), 64'(br));
        check_output({tag, " illegal"},    64'(cu_bus.cu_illegal), 64'(ill));
        check_output({tag, " addr_a"},     64'(cu_bus.cu_rf_addr_a), 64'(held.a));
        check_output({tag, " addr_b"},     64'(cu_bus.cu_rf_addr_b), 64'(held.b));
        check_output({tag, " write_addr"}, 64'(cu_bus.cu_rf_write_addr), 64'(held.wa));
        check_output({tag, " immediate"},  cu_bus.cu_immediate, held.imm);
        check_output({tag, " mux_0"},      64'(cu_bus.cu_mux_0_sel), 64'd0);
        check_output({tag, " mux_1"},      64'(cu_bus.cu_mux_1_sel), 64'(held.mux1));
        check_output({tag, " mux_2"},      64'(cu_bus.cu_mux_2_sel), 64'(held.mux2));
        check_output({tag, " alu_op"},     64'(cu_bus.cu_alu_operation), 64'(held.op));
    endtask

    // Called at a falling edge while the DUT is idle; returns at the falling
    // edge of the first idle cycle afterwards, so calls chain back-to-back.
    task automatic apply_stimulus(input logic [31:0] ins, input logic zero,
                                  input model_t exp);
        int  n;
        logic writes;
        n = cycles_of(exp.kind);
        writes = (exp.kind == K_REG || exp.kind == K_LOAD) && (exp.wa != 5'd0);
        cu_bus.cu_instr       = ins;
        cu_bus.cu_instr_valid = 1'b1;
        cu_bus.cu_alu_zero    = zero;
        @(posedge clk);
        if (exp.kind != K_ILLEGAL) held = exp;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check_cycle($sformatf("%08h c%0d", ins, k), (k == n),
                        writes && (k == n - 1),
                        (exp.kind == K_STORE) && (k == 3),
                        (exp.kind == K_BRANCH) && (k == 2) && zero,
                        (exp.kind == K_ILLEGAL) && (k == 1));
            if (k < n) begin
                cu_bus.cu_instr_valid = 1'($urandom_range(0, 1));
                cu_bus.cu_instr       = $urandom;
            end else begin
                cu_bus.cu_instr_valid = 1'b0;
            end
        end
    endtask

    vector_t table_v[10];

    initial begin
        table_v[0] = '{32'h0053B103, 1'b0, make_exp(K_LOAD,   5'd7, 5'd0, 5'd2, 64'd5, 1'b0, 1'b1, 3'd0)};
        table_v[1] = '{32'h002081B3, 1'b0, make_exp(K_REG,    5'd1, 5'd2, 5'd3, 64'd0, 1'b1, 1'b0, 3'd0)};
        table_v[2] = '{32'h402081B3, 1'b0, make_exp(K_REG,    5'd1, 5'd2, 5'd3, 64'd0, 1'b1, 1'b0, 3'd1)};
        table_v[3] = '{32'hFE533C23, 1'b0, make_exp(K_STORE,  5'd6, 5'd5, 5'd0, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1'b0, 3'd0)};
        table_v[4] = '{32'h00108463, 1'b1, make_exp(K_BRANCH, 5'd1, 5'd1, 5'd0, 64'd8, 1'b1, 1'b0, 3'd1)};
        table_v[5] = '{32'h00108463, 1'b0, make_exp(K_BRANCH, 5'd1, 5'd1, 5'd0, 64'd8, 1'b1, 1'b0, 3'd1)};
        table_v[6] = '{32'h00000000, 1'b0, make_exp(K_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 3'd0)};
        table_v[7] = '{32'h00100013, 1'b0, make_exp(K_REG,    5'd0, 5'd0, 5'd0, 64'd1, 1'b0, 1'b0, 3'd0)};
        table_v[8] = '{32'h0062C233, 1'b0, make_exp(K_REG,    5'd5, 5'd6, 5'd4, 64'd0, 1'b1, 1'b0, 3'd4)};
        table_v[9] = '{32'h202081B3, 1'b0, make_exp(K_ILLEGAL, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 3'd0)};

        held = make_exp(K_REG, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 3'd0);
        cu_bus.cu_instr       = 32'h0;
        cu_bus.cu_instr_valid = 1'b0;
        cu_bus.cu_alu_zero    = 1'b0;

        // Reset state, then release with no instruction pending.
        repeat (2) @(negedge clk);
        check_cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_cycle("after reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed vectors, applied back-to-back.
        for (int i = 0; i < 10; i++)
            apply_stimulus(table_v[i].instr, table_v[i].zero, table_v[i].exp);

        // Reset in the middle of an ADD write-back cycle.
        cu_bus.cu_instr       = 32'h002081B3;
        cu_bus.cu_instr_valid = 1'b1;
        @(posedge clk);
        held = model_decode(32'h002081B3);
        @(negedge clk);
        cu_bus.cu_instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("pre-reset wb rf_write_en", 64'(cu_bus.cu_rf_write_en), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        held = make_exp(K_REG, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b0, 3'd0);
        check_cycle("mid-wb reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_cycle($sformatf("post-reset idle %0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Randomized instructions against the model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] w;
            w = random_instr();
            apply_stimulus(w, 1'($urandom_range(0, 1)), model_decode(w));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle RV64 control FSM that drives the datapath control inputs of `cpu`: register-file addresses and write enable, immediate, mux selects, ALU operation and data-memory write enable.
- Accepts one 32-bit instruction through a valid/ready handshake, decodes it, then steps the datapath through EXEC/MEM/WB one state per clock.

Parameters:
WORDSIZE, 64, datapath word width; width of the sign-extended immediate.

Ports:
cu_clk  input  1  clock; all state updates on rising edge
cu_rst_n  input  1  asynchronous active-low reset
cu_instr  input  32  instruction word, sampled only on accept
cu_instr_valid  input  1  instruction present
cu_instr_ready  output  1  high only in IDLE
cu_alu_zero  input  1  ALU result == 0, from datapath
cu_rf_addr_a  output  5  rs1
cu_rf_addr_b  output  5  rs2 (0 for I-type)
cu_rf_write_addr  output  5  rd
cu_rf_write_en  output  1  register-file write strobe
cu_immediate  output  WORDSIZE  sign-extended immediate
cu_mux_0_sel  output  1  0 = rf_data_a into ALU A
cu_mux_1_sel  output  1  0 = immediate, 1 = rf_data_b into ALU B
cu_mux_2_sel  output  1  0 = ALU result, 1 = dm data to writeback
cu_alu_operation  output  3  0 add, 1 sub, 2 and, 3 or, 4 xor
cu_dm_write_en  output  1  data-memory write strobe
cu_branch_taken  output  1  one-cycle pulse, BEQ taken
cu_illegal  output  1  one-cycle pulse, unsupported instruction

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0 except cu_instr_ready=1. Strobes drop immediately, even mid-instruction.
- States: IDLE, DECODE, EXEC, MEM, WB.
- Accept: in IDLE, when cu_instr_valid=1, latch cu_instr into the instruction register and go to DECODE. cu_instr_valid outside IDLE is ignored.
- DECODE:
  - Field outputs are registered here and held until return to IDLE: addr_a, addr_b, write_addr, immediate, mux selects, alu_operation.
  - Unsupported opcode/funct → cu_illegal=1 for exactly this cycle, then IDLE; no strobe ever asserts for it.
  - Otherwise go to EXEC.
- Supported instructions:
  - ADD/SUB/AND/OR/XOR (opcode 0110011, funct7 0x00 or SUB 0x20): mux_1=1, ALU op per funct.
  - ADDI (0010011, f3 000): I-immediate, mux_1=0, op add.
  - LD (0000011, f3 011): I-immediate, op add, mux_2=1.
  - SD (0100011, f3 011): S-immediate, op add.
  - BEQ (1100011, f3 000): B-immediate, mux_1=1, op sub.
- Sequences (cycles counted from accept edge):
  - R-type/ADDI: DECODE→EXEC→WB→IDLE, 4 cycles.
  - LD: DECODE→EXEC→MEM→WB→IDLE, 5 cycles.
  - SD: DECODE→EXEC→MEM→IDLE; cu_dm_write_en=1 only in MEM; 4 cycles.
  - BEQ: DECODE→EXEC→IDLE; cu_branch_taken = cu_alu_zero sampled in EXEC, asserted that cycle only; 3 cycles.
- Strobes are Moore outputs, decoded from the state register only:
  - cu_rf_write_en=1 only in WB, and only when rd≠0; rd=0 suppresses the write, but the FSM still passes through WB.
  - cu_dm_write_en=1 only in the SD MEM state.
- Immediates sign-extend bit 31 to WORDSIZE bits. B-immediate bit 0 = 0. R-type immediate = 0.
- Field regs keep the last decoded values in IDLE; strobes are 0 in IDLE.
- Back-to-back: a new instruction may be accepted on the first IDLE cycle.

Test Plan:
- Reset: cu_rst_n low mid-WB of ADD → same-cycle rf_write_en=0, instr_ready=1. After release, outputs hold reset values until the next accept.
- LD x2,5(x7), instr 0x0053B103 → addr_a=7, write_addr=2, immediate=5, mux_0=0, mux_1=0, alu_op=0. mux_2=1 held from DECODE through WB. rf_write_en=1 exactly at accept+4. ready returns at accept+5.
- ADD 0x002081B3 then SUB 0x402081B3 back-to-back → addr_a=1, addr_b=2, write_addr=3, mux_1=1. alu_op=0 then 1. One rf_write_en pulse each, 4 cycles apart.
- SD x5,-8(x6), 0xFE533C23 → immediate=0xFFFFFFFFFFFFFFF8, addr_a=6, addr_b=5. dm_write_en=1 for one cycle at accept+3. rf_write_en never 1.
- BEQ x1,x1,+8, 0x00108463 with alu_zero=1 → immediate=8, alu_op=1, branch_taken pulse at accept+2. Repeat with alu_zero=0 → no pulse.
- Illegal 0x00000000 → illegal=1 at accept+1 only, no strobes. ADDI x0,x0,1 (0x00100013) → WB visited, rf_write_en stays 0.
